// File: rtl/fc_share_arbiter.sv
`default_nettype none
// fc_share_arbiter: round-robin sharing of one FC MAC engine between two requesters.
// A grant covers a whole transaction (M words in, N results out); rev 1.0.
module fc_share_arbiter #(
    parameter int WIDTH = 16,
    parameter int M     = 8,
    parameter int N     = 8,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             eng_in_valid,
    input  logic             eng_in_ready,
    output logic [WIDTH-1:0] eng_in_data,
    input  logic             eng_out_valid,
    output logic             eng_out_ready,
    input  logic [WIDTH-1:0] eng_out_data,
    output logic             owner,
    output logic             busy,
    output logic [CNTW-1:0]  done_cnt0,
    output logic [CNTW-1:0]  done_cnt1
);

    localparam int INW = (M > 1) ? $clog2(M) : 1;
    localparam int ONW = (N > 1) ? $clog2(N) : 1;
    localparam logic [INW-1:0] IN_LAST  = INW'(M - 1);
    localparam logic [ONW-1:0] OUT_LAST = ONW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [INW-1:0]  in_cnt_q, in_cnt_d;
    logic [ONW-1:0]  out_cnt_q, out_cnt_d;
    logic [CNTW-1:0] done_cnt0_q, done_cnt0_d;
    logic [CNTW-1:0] done_cnt1_q, done_cnt1_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            done_cnt0_q <= '0;
            done_cnt1_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            done_cnt0_q <= done_cnt0_d;
            done_cnt1_q <= done_cnt1_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        in_cnt_d      = in_cnt_q;
        out_cnt_d     = out_cnt_q;
        done_cnt0_d   = done_cnt0_q;
        done_cnt1_d   = done_cnt1_q;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        rsp0_valid    = 1'b0;
        rsp1_valid    = 1'b0;
        rsp0_data     = '0;
        rsp1_data     = '0;
        eng_in_valid  = 1'b0;
        eng_in_data   = '0;
        eng_out_ready = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the requester not served last wins.
                if (req0_valid && req1_valid) begin
                    owner_d = ~last_q;
                    state_d = FEED;
                end else if (req0_valid) begin
                    owner_d = 1'b0;
                    state_d = FEED;
                end else if (req1_valid) begin
                    owner_d = 1'b1;
                    state_d = FEED;
                end
            end
            FEED: begin
                eng_in_valid = owner_q ? req1_valid : req0_valid;
                eng_in_data  = owner_q ? req1_data : req0_data;
                req0_ready   = ~owner_q & eng_in_ready;
                req1_ready   = owner_q & eng_in_ready;
                if (eng_in_valid && eng_in_ready) begin
                    if (in_cnt_q == IN_LAST) begin
                        in_cnt_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        in_cnt_d = in_cnt_q + INW'(1);
                    end
                end
            end
            DRAIN: begin
                rsp0_valid    = ~owner_q & eng_out_valid;
                rsp1_valid    = owner_q & eng_out_valid;
                rsp0_data     = owner_q ? '0 : eng_out_data;
                rsp1_data     = owner_q ? eng_out_data : '0;
                eng_out_ready = owner_q ? rsp1_ready : rsp0_ready;
                if (eng_out_valid && eng_out_ready) begin
                    if (out_cnt_q == OUT_LAST) begin
                        out_cnt_d = '0;
                        last_d    = owner_q;
                        state_d   = IDLE;
                        if (owner_q) begin
                            done_cnt1_d = done_cnt1_q + CNTW'(1);
                        end else begin
                            done_cnt0_d = done_cnt0_q + CNTW'(1);
                        end
                    end else begin
                        out_cnt_d = out_cnt_q + ONW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign owner     = owner_q;
    assign busy      = (state_q != IDLE);
    assign done_cnt0 = done_cnt0_q;
    assign done_cnt1 = done_cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_share_arbiter.sv
`default_nettype none
// tb_fc_share_arbiter: scoreboard bench with requester, consumer and engine models.
module tb_fc_share_arbiter;
    localparam int W = 16, M = 8, N = 8, CW = 16;
    typedef logic [W-1:0] word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    word_t req0_data = 0, req1_data = 0;
    logic rsp0_valid, rsp1_valid, rsp0_ready = 0, rsp1_ready = 0;
    word_t rsp0_data, rsp1_data;
    logic eng_in_valid, eng_in_ready = 0, eng_out_valid = 0, eng_out_ready;
    word_t eng_in_data, eng_out_data = 0;
    logic owner, busy;
    logic [CW-1:0] done_cnt0, done_cnt1;

    fc_share_arbiter #(.WIDTH(W), .M(M), .N(N), .CNTW(CW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .eng_in_valid(eng_in_valid), .eng_in_ready(eng_in_ready), .eng_in_data(eng_in_data),
        .eng_out_valid(eng_out_valid), .eng_out_ready(eng_out_ready), .eng_out_data(eng_out_data),
        .owner(owner), .busy(busy), .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
    );

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stimulus queues (words to send) and scoreboard queues (results expected).
    word_t wq0[$], wq1[$], xq0[$], xq1[$];
    word_t ebuf[$];
    word_t eres[N];
    bit    eng_phase = 0;
    int    ek = 0;
    int    req_pct = 100, rsp_pct = 100, eng_pct = 100;
    bit    rsp_hold0 = 0, ein_toggle = 0, tog = 0, rst_drive = 1;
    bit    hs_r0 = 0, hs_r1 = 0, hs_ein = 0, hs_eout = 0;
    word_t ein_d = 0;
    int    mdone0 = 0, mdone1 = 0, rcnt0 = 0, rcnt1 = 0;
    int    ein_total = 0;
    bit    prev_busy = 0, r1_seen = 0;
    int    grant_q[$];

    function automatic word_t fc_res(input word_t w[M], input int j);
        int acc = 0;
        for (int i = 0; i < M; i++) acc += int'(w[i]) * (i + j + 1);
        return word_t'(acc + j);
    endfunction

    task automatic push_txn(input int x, input bit seq);
        word_t w[M];
        for (int i = 0; i < M; i++) begin
            w[i] = seq ? word_t'(i + 1) : word_t'($urandom);
            if (x == 0) wq0.push_back(w[i]); else wq1.push_back(w[i]);
        end
        for (int j = 0; j < N; j++) begin
            if (x == 0) xq0.push_back(fc_res(w, j)); else xq1.push_back(fc_res(w, j));
        end
    endtask

    function automatic bit quiet();
        return !busy && wq0.size() == 0 && wq1.size() == 0 && xq0.size() == 0 &&
               xq1.size() == 0 && !eng_phase;
    endfunction

    // One cycle: drive just after the rising edge, observe at the falling edge.
    task automatic tick();
        word_t w[M];
        @(posedge clk);
        #1;
        reset = rst_drive;
        if (rst_drive) begin
            wq0.delete(); wq1.delete(); xq0.delete(); xq1.delete(); ebuf.delete();
            eng_phase = 0; ek = 0; mdone0 = 0; mdone1 = 0; rcnt0 = 0; rcnt1 = 0;
            prev_busy = 0;
            req0_valid = 0; req1_valid = 0; req0_data = 0; req1_data = 0;
            rsp0_ready = 0; rsp1_ready = 0; eng_in_ready = 0;
            eng_out_valid = 0; eng_out_data = 0;
        end else begin
            if (hs_r0) void'(wq0.pop_front());
            if (hs_r1) void'(wq1.pop_front());
            if (hs_ein) begin
                ebuf.push_back(ein_d);
                ein_total++;
                if (ebuf.size() == M) begin
                    for (int i = 0; i < M; i++) w[i] = ebuf[i];
                    for (int j = 0; j < N; j++) eres[j] = fc_res(w, j);
                    ebuf.delete();
                    eng_phase = 1;
                    ek = 0;
                end
            end
            if (hs_eout) begin
                ek++;
                if (ek == N) eng_phase = 0;
            end
            // A valid already raised and not yet accepted is held with its data.
            if (wq0.size() > 0) begin
                if (!(req0_valid && !hs_r0)) req0_valid = ($urandom_range(99) < req_pct);
                req0_data = wq0[0];
            end else begin
                req0_valid = 0; req0_data = 0;
            end
            if (wq1.size() > 0) begin
                if (!(req1_valid && !hs_r1)) req1_valid = ($urandom_range(99) < req_pct);
                req1_data = wq1[0];
            end else begin
                req1_valid = 0; req1_data = 0;
            end
            rsp0_ready = rsp_hold0 ? 1'b0 : ($urandom_range(99) < rsp_pct);
            rsp1_ready = ($urandom_range(99) < rsp_pct);
            tog = ~tog;
            eng_in_ready = !eng_phase && (ein_toggle ? tog : ($urandom_range(99) < eng_pct));
            if (eng_phase) begin
                if (!(eng_out_valid && !hs_eout)) eng_out_valid = ($urandom_range(99) < eng_pct);
                eng_out_data = eres[ek];
            end else begin
                eng_out_valid = 0; eng_out_data = 0;
            end
        end
        @(negedge clk);
        if (reset) begin
            hs_r0 = 0; hs_r1 = 0; hs_ein = 0; hs_eout = 0;
        end else begin
            hs_r0   = req0_valid & req0_ready;
            hs_r1   = req1_valid & req1_ready;
            hs_ein  = eng_in_valid & eng_in_ready;
            hs_eout = eng_out_valid & eng_out_ready;
            ein_d   = eng_in_data;
            if (rsp0_valid && rsp0_ready) begin
                if (xq0.size() == 0) chk("rsp0_extra", 1, 0);
                else begin
                    chk("rsp0_data", rsp0_data, xq0.pop_front());
                    rcnt0++;
                    if (rcnt0 == N) begin rcnt0 = 0; mdone0++; end
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                if (xq1.size() == 0) chk("rsp1_extra", 1, 0);
                else begin
                    chk("rsp1_data", rsp1_data, xq1.pop_front());
                    rcnt1++;
                    if (rcnt1 == N) begin rcnt1 = 0; mdone1++; end
                end
            end
            chk("rdy_mutex", req0_ready & req1_ready, 0);
            chk("rsp_mutex", rsp0_valid & rsp1_valid, 0);
            chk("eout_early", eng_out_ready & !eng_phase, 0);
            if (!busy)
                chk("idle_quiet", {req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                                   eng_in_valid, eng_out_ready}, 0);
            if (busy && !prev_busy) grant_q.push_back(int'(owner));
            prev_busy = busy;
            r1_seen = r1_seen | req1_ready | rsp1_valid;
        end
    endtask

    task automatic do_reset();
        rst_drive = 1; tick();
        rst_drive = 0; tick();
    endtask

    task automatic wait_quiet(input string tag, input int maxc);
        int n = 0;
        do begin tick(); n++; end while (!quiet() && n < maxc);
        chk(tag, quiet(), 1);
    endtask

    initial begin
        int    n, base, g;
        word_t held;
        int    exp_g[3] = '{0, 1, 0};

        // Reset state
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_done0", done_cnt0, 0);
        chk("rst_done1", done_cnt1, 0);
        chk("rst_outs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                         eng_in_valid, eng_out_ready}, 0);

        // Single requester, words 1..8, everything ready: exact cycle timing
        r1_seen = 0;
        push_txn(0, 1);
        tick();
        chk("t1_req_idle", {req0_valid, busy}, 2'b10);
        for (int i = 1; i <= M; i++) begin
            tick();
            chk("t1_hs", hs_ein, 1);
            chk("t1_word", ein_d, i);
        end
        wait_quiet("t1_quiet", 100);
        chk("t1_done0", done_cnt0, 1);
        chk("t1_done_sb", mdone0, 1);
        chk("t1_r1_silent", r1_seen, 0);

        // Ties after reset: req0 first, then alternation
        do_reset();
        grant_q.delete();
        push_txn(0, 0); push_txn(0, 0); push_txn(1, 0);
        wait_quiet("t2_quiet", 300);
        chk("t2_ngrant", grant_q.size(), 3);
        for (int k = 0; k < 3; k++) begin
            g = (k < grant_q.size()) ? grant_q[k] : 99;
            chk($sformatf("t2_grant%0d", k), g, exp_g[k]);
        end
        chk("t2_done0", done_cnt0, 2);
        chk("t2_done1", done_cnt1, 1);

        // Engine input ready toggling
        ein_toggle = 1;
        base = ein_total;
        push_txn(1, 0);
        wait_quiet("t3_quiet", 300);
        chk("t3_in_hs", ein_total - base, M);
        chk("t3_done1", done_cnt1, 2);
        ein_toggle = 0;

        // Consumer stall for 5 cycles with engine output valid
        rsp_hold0 = 1;
        push_txn(0, 0);
        n = 0;
        while (!eng_out_valid && n < 60) begin tick(); n++; end
        chk("t4_eout_seen", eng_out_valid, 1);
        held = eng_out_data;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_eout_rdy", eng_out_ready, 0);
            chk("t4_rsp_v", rsp0_valid, 1);
            chk("t4_rsp_d", rsp0_data, held);
            chk("t4_no_hs", hs_eout, 0);
        end
        rsp_hold0 = 0;
        wait_quiet("t4_quiet", 200);
        chk("t4_done0", done_cnt0, 3);

        // Reset after 4 of 8 input words, then a fresh req1 transaction
        base = ein_total;
        push_txn(0, 1);
        n = 0;
        while ((ein_total + int'(hs_ein) - base) < 4 && n < 60) begin tick(); n++; end
        chk("t5_four_in", ein_total + int'(hs_ein) - base, 4);
        do_reset();
        chk("t5_busy", busy, 0);
        chk("t5_rdys", {req0_ready, req1_ready, eng_in_valid, eng_out_ready}, 0);
        chk("t5_cnt_clr", {done_cnt0, done_cnt1}, 0);
        push_txn(1, 1);
        wait_quiet("t5_quiet", 200);
        chk("t5_done1", done_cnt1, 1);
        chk("t5_done0", done_cnt0, 0);

        // Random stalls on every handshake, 200 transactions
        req_pct = 60; rsp_pct = 70; eng_pct = 70;
        for (int k = 0; k < 100; k++) begin
            push_txn(0, 0);
            push_txn(1, 0);
        end
        wait_quiet("t6_quiet", 40000);
        chk("t6_done0", done_cnt0, 100);
        chk("t6_done1", done_cnt1, 101);
        chk("t6_sb0", mdone0, 100);
        chk("t6_sb1", mdone1, 101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
